lsu: RTL

Load/store unit directly downstream of the instruction decoder/control block in the single-cycle core. Takes the decoder's memory access request (access size, write enable, sign-extend), the ALU-computed address and the rs2 store data, and runs one access on a simple req/gnt/rvalid data bus. Returns aligned, extended load data to register writeback. Pulses `ready_o`, which feeds the decoder's `mem_wr_ready_i` and releases the PC stall.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_if.sv | 20 ++
 rtl/lsu_mem_align.sv | 70 +++++++
 rtl/lsu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
//   - lane geometry of the 32-bit data bus (NUM_LANES byte lanes of VEC_W bits)
//   - memory access size encoding used by the decoder (acc_r/acc_w)
//   - LSU FSM state encoding
//   - latched request record
package lsu_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int XLEN      = NUM_LANES * VEC_W;

  typedef enum logic [1:0] {
    MEM_ACC_NONE = 2'b00,
    MEM_ACC_B    = 2'b01,
    MEM_ACC_H    = 2'b10,
    MEM_ACC_W    = 2'b11
  } mem_acc_e;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'b00,
    LSU_ST_REQ  = 2'b01,
    LSU_ST_RSP  = 2'b10,
    LSU_ST_DONE = 2'b11
  } lsu_st_e;

  // One data-bus lane per byte.
  typedef logic [NUM_LANES-1:0][VEC_W-1:0] lanes_t;

  // Request captured at accept; held for the whole access.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    mem_acc_e        size;
    logic            we;
    logic            sext;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Simple req/gnt/rvalid data bus.
//   master (LSU side): drives req, we, addr (word aligned), be, wdata;
//                      receives gnt, rvalid, rdata.
//   slave  (memory side): the mirror image.
interface lsu_if;
  import lsu_pkg::*;

  logic                 req;
  logic                 we;
  logic [XLEN-1:0]      addr;
  logic [NUM_LANES-1:0] be;
  logic [XLEN-1:0]      wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [XLEN-1:0]      rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/lsu_mem_align.sv
// Combinational access aligner for the LSU.
//   size, ofs  : access size and byte offset (addr[1:0])
//   sext       : sign-extend the load result
//   wdata      : raw store data (rs2)
//   rdata      : raw bus read word
//   be         : byte enables for the access
//   wlanes     : store data replicated onto every lane it may land on
//   rext       : selected, extended load result
//   misal      : half on odd address or word on non-word address
module lsu_mem_align
  import lsu_pkg::*;
(
  input  mem_acc_e             size,
  input  logic [1:0]           ofs,
  input  logic                 sext,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata,
  output logic [NUM_LANES-1:0] be,
  output lanes_t               wlanes,
  output logic [XLEN-1:0]      rext,
  output logic                 misal
);

  lanes_t wsrc;
  assign wsrc = wdata;

  // Per lane: enable when the access covers it, and pick the source byte.
  // Byte stores feed lane 0 everywhere, half stores alternate lanes 0/1.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic             be_l;
    logic [VEC_W-1:0] wl_l;

    always_comb begin
      be_l = 1'b0;
      wl_l = wsrc[i];
      case (size)
        MEM_ACC_B: begin
          be_l = (ofs == 2'(i));
          wl_l = wsrc[0];
        end
        MEM_ACC_H: begin
          be_l = (ofs[1] == 1'(i / 2));
          wl_l = wsrc[i % 2];
        end
        MEM_ACC_W: be_l = 1'b1;
        default: ;
      endcase
    end

    assign be[i]     = be_l;
    assign wlanes[i] = wl_l;
  end

  // Load: bring the addressed lane down to bit 0, then extend.
  logic [XLEN-1:0] sh;

  always_comb begin
    sh   = rdata >> {ofs, 3'b000};
    rext = sh;
    case (size)
      MEM_ACC_B: rext = {{(XLEN-VEC_W){sext & sh[VEC_W-1]}}, sh[VEC_W-1:0]};
      MEM_ACC_H: rext = {{(XLEN-2*VEC_W){sext & sh[2*VEC_W-1]}}, sh[2*VEC_W-1:0]};
      default: ;
    endcase
  end

  assign misal = ((size == MEM_ACC_H) && ofs[0]) ||
                 ((size == MEM_ACC_W) && (ofs != 2'b00));

endmodule

// File: rtl/lsu.sv
// Load/store unit. Runs one memory access per decoder request on the
// req/gnt/rvalid bus and pulses ready_o to release the PC stall.
//   clk_i, rstn_i        : clock, async active-low reset
//   acc_r_i / acc_w_i    : load / store size (none, byte, half, word)
//   wr_en_i              : store request (needs acc_w_i != 0)
//   sext_i               : sign-extend load result
//   addr_i, wdata_i      : byte address, store data
//   ready_o              : one-cycle completion pulse
//   err_o                : misaligned or timed out, only with ready_o
//   rdata_o              : load result, held until the next accept
//   bus                  : data bus master port
// BUS_TIMEOUT bounds the cycles spent in REQ+RSP (0 = no limit, values
// above 65536 are truncated to the 16-bit counter).
module lsu
  import lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [1:0]      acc_r_i,
  input  logic [1:0]      acc_w_i,
  input  logic            wr_en_i,
  input  logic            sext_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ready_o,
  output logic            err_o,
  output logic [XLEN-1:0] rdata_o,
  lsu_if.master           bus
);

  localparam int            CW      = 16;
  localparam logic [CW-1:0] TMO_LIM = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  lsu_st_e              st_q, st_d;
  lsu_req_t             req_q, req_d;
  logic [NUM_LANES-1:0] be_q;
  lanes_t               wd_q;
  logic [XLEN-1:0]      rdata_q;
  logic                 err_q;
  logic [CW-1:0]        cnt_q;

  logic                 is_st, is_ld, acc, tmo;
  mem_acc_e             a_size;
  logic [1:0]           a_ofs;
  logic                 a_sext;
  logic [NUM_LANES-1:0] a_be;
  lanes_t               a_wl;
  logic [XLEN-1:0]      a_rext;
  logic                 a_mis;

  // Request decode: a valid store overrides a simultaneous load.
  assign is_st = wr_en_i && (acc_w_i != 2'b00);
  assign is_ld = (acc_r_i != 2'b00);
  assign acc   = (st_q == LSU_ST_IDLE) && (is_st || is_ld);

  always_comb begin
    req_d.addr = addr_i;
    req_d.we   = is_st;
    req_d.sext = sext_i;
    req_d.size = is_st ? mem_acc_e'(acc_w_i) : mem_acc_e'(acc_r_i);
  end

  // One aligner serves both ends of the access: in IDLE it sees the live
  // request (enables, store lanes, misalign); afterwards the latched one
  // (load extract).
  assign a_size = (st_q == LSU_ST_IDLE) ? req_d.size      : req_q.size;
  assign a_ofs  = (st_q == LSU_ST_IDLE) ? addr_i[1:0]     : req_q.addr[1:0];
  assign a_sext = (st_q == LSU_ST_IDLE) ? sext_i          : req_q.sext;

  lsu_mem_align u_align (
    .size   (a_size),
    .ofs    (a_ofs),
    .sext   (a_sext),
    .wdata  (wdata_i),
    .rdata  (bus.rdata),
    .be     (a_be),
    .wlanes (a_wl),
    .rext   (a_rext),
    .misal  (a_mis)
  );

  // cnt_q counts completed REQ/RSP cycles, so this is the last allowed one.
  assign tmo = (BUS_TIMEOUT != 0) && (cnt_q >= TMO_LIM);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) st_q <= LSU_ST_IDLE;
    else         st_q <= st_d;
  end

  // A real grant/rvalid in the final allowed cycle still completes normally.
  always_comb begin
    st_d = st_q;
    case (st_q)
      LSU_ST_IDLE: if (is_st || is_ld) st_d = a_mis ? LSU_ST_DONE : LSU_ST_REQ;
      LSU_ST_REQ: begin
        if (bus.gnt)  st_d = req_q.we ? LSU_ST_DONE : LSU_ST_RSP;
        else if (tmo) st_d = LSU_ST_DONE;
      end
      LSU_ST_RSP:  if (bus.rvalid || tmo) st_d = LSU_ST_DONE;
      LSU_ST_DONE: st_d = LSU_ST_IDLE;
      default:     st_d = LSU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_q   <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= '0;
      if (acc) begin
        req_q <= req_d;
        be_q  <= a_be;
        wd_q  <= a_wl;
        err_q <= a_mis;
        if (a_mis) rdata_q <= '0;
      end
      if ((st_q == LSU_ST_REQ) || (st_q == LSU_ST_RSP)) begin
        if (BUS_TIMEOUT != 0) cnt_q <= cnt_q + CW'(1);
      end
      if ((st_q == LSU_ST_REQ) && !bus.gnt && tmo) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
      if (st_q == LSU_ST_RSP) begin
        if (bus.rvalid) begin
          rdata_q <= a_rext;
        end else if (tmo) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign ready_o   = (st_q == LSU_ST_DONE);
  assign err_o     = ready_o & err_q;
  assign rdata_o   = rdata_q;

  assign bus.req   = (st_q == LSU_ST_REQ);
  assign bus.we    = req_q.we;
  assign bus.addr  = {req_q.addr[XLEN-1:2], 2'b00};
  assign bus.be    = be_q;
  assign bus.wdata = wd_q;

endmodule
